// File: rtl/ifetch_seq.sv
// Sequential instruction-fetch stage: holds the PC, fetches one word per instruction over a
// ready handshake, presents it for a single commit cycle and then advances the PC.
module ifetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 14
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_ready,
    input  logic               stall,
    input  logic               Jr,
    input  logic               Jmp,
    input  logic               Jal,
    input  logic               Branch,
    input  logic               nBranch,
    input  logic               Zero,
    input  logic [31:0]        Addr_result,
    input  logic [31:0]        Read_data_1,
    output logic [31:0]        Instruction,
    output logic               exec_en,
    output logic [31:0]        pc,
    output logic [31:0]        branch_base_addr,
    output logic [31:0]        link_addr,
    output logic               addr_err
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_link;
    logic        r_err;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_commit;
    logic        w_capture;
    logic        w_jr_misaligned;

    // Priority: jr, then j/jal, then conditional branch, then fall-through.
    function automatic logic [31:0] calc_next_pc(
        input logic [31:0] instr,
        input logic [31:0] pc4,
        input logic        jr,
        input logic        jmp,
        input logic        jal,
        input logic        br,
        input logic        nbr,
        input logic        zero,
        input logic [31:0] br_target,
        input logic [31:0] rs_val
    );
        logic [31:0] v;
        if (jr) begin
            v = {rs_val[31:2], 2'b00};
        end else if (jmp || jal) begin
            v = {pc4[31:28], instr[25:0], 2'b00};
        end else if ((br && zero) || (nbr && !zero)) begin
            v = br_target;
        end else begin
            v = pc4;
        end
        return v;
    endfunction

    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_next_pc       = calc_next_pc(r_instr, w_pc_plus4, Jr, Jmp, Jal, Branch, nBranch,
                                          Zero, Addr_result, Read_data_1);
    assign w_jr_misaligned = Jr && (Read_data_1[1:0] != 2'b00);

    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        exec_en     = 1'b0;
        w_commit    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                exec_en  = ~stall;
                w_commit = ~stall;
                if (!stall) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
            r_instr <= 32'h0000_0000;
            r_link  <= 32'h0000_0000;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_instr <= imem_rdata;
            end
            // A malformed jr+jal decode still records the link address.
            if (w_commit) begin
                r_pc <= w_next_pc;
                if (Jal) begin
                    r_link <= w_pc_plus4;
                end
                if (w_jr_misaligned) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Upper PC bits are kept but not presented, so memory aliases above IMEM_AW.
    assign imem_addr        = r_pc[IMEM_AW+1:2];
    assign branch_base_addr = w_pc_plus4;
    assign Instruction      = r_instr;
    assign pc               = r_pc;
    assign link_addr        = r_link;
    assign addr_err         = r_err;

endmodule

// File: doc/ifetch_seq.md
Name: ifetch_seq

Overview:
- Sequential instruction-fetch stage of the 32-bit MIPS-subset CPU; sits directly upstream of the combinational control decoder.
- Holds the PC and requests words from instruction memory over a ready handshake.
- Presents a stable Instruction to the decoder/datapath for one commit cycle.
- Computes the next PC from the decoder's Jr/Jmp/Jal/Branch/nBranch outputs and the ALU's Zero/Addr_result. Also produces PC+4 and the latched link address for jal.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 14, instruction memory word-address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  IMEM_AW  word address, equal to PC[IMEM_AW+1:2].
- imem_rdata  in  32  instruction word from memory.
- imem_ready  in  1  imem_rdata is valid this cycle.
- stall  in  1  hold the current instruction and do not commit.
- Jr, Jmp, Jal, Branch, nBranch  in  1 each  decoder outputs for the held Instruction.
- Zero  in  1  ALU equality result.
- Addr_result  in  32  branch target from the ALU.
- Read_data_1  in  32  rs value, used as the jr target.
- Instruction  out  32  held instruction word.
- exec_en  out  1  commit strobe: the datapath writes registers/memory only when this is 1.
- pc  out  32  current PC.
- branch_base_addr  out  32  pc+4 (combinational).
- link_addr  out  32  pc+4 of the last committed jal.
- addr_err  out  1  sticky flag: a misaligned jr target was seen.

Behaviour:
- Reset (reset==0 at a rising edge), regardless of state:
  - state=BOOT, pc=RESET_PC, Instruction=0 (nop), link_addr=0, addr_err=0.
  - imem_req=0, exec_en=0.
  - A request in flight is abandoned, and any later imem_ready is ignored until the FETCH state.
- States:
  - BOOT: imem_req=0. Next cycle goes to FETCH.
  - FETCH: imem_req=1, imem_addr=PC[IMEM_AW+1:2]. When imem_ready=1, Instruction<=imem_rdata and the state goes to EXEC. Otherwise it stays in FETCH with the address held stable.
  - EXEC: imem_req=0, Instruction held. exec_en = ~stall.
    - stall=1: stay in EXEC; pc and link_addr unchanged.
    - stall=0: pc<=next_pc, link_addr<=pc+4 if Jal, then go to FETCH.
- imem_ready is ignored outside FETCH.
- Minimum cost is 2 cycles per instruction (ready asserted in the first FETCH cycle). Each extra wait cycle adds 1.
- next_pc, first match wins:
  1. Jr: {Read_data_1[31:2], 2'b00}. If Read_data_1[1:0]!=0, addr_err<=1 (sticky until reset).
  2. Jmp|Jal: {pc_plus4[31:28], Instruction[25:0], 2'b00}.
  3. (Branch&Zero)|(nBranch&~Zero): Addr_result.
  4. Otherwise: pc_plus4.
- pc_plus4 = pc+4, mod 2^32 (0xFFFF_FFFC wraps to 0).
- PC bits above IMEM_AW+1 are kept in pc but not driven on imem_addr, so the memory aliases.
- Control inputs are sampled only on the EXEC commit edge. Values in other states are don't-care.
- Simultaneous Jr and Jal (malformed decode): Jr wins; link_addr still updates because Jal=1.
- All outputs are registered except imem_addr, imem_req, exec_en and branch_base_addr, which are combinational from state/pc.

Test Plan:
1. Reset release, ready tied high, rdata=32'h2008_0005 → BOOT, FETCH (imem_addr=0), EXEC with exec_en=1 and Instruction=0x20080005; pc=4 two cycles later.
2. Sequential run at pc=0x3C, ready delayed 3 cycles → imem_req stays 1 with imem_addr=0x0F for 4 cycles, no exec_en; after commit pc=0x40.
3. beq taken: Branch=1, Zero=1, Addr_result=0x100 → pc=0x100. Repeat with Zero=0 → pc=pc+4. bne with Zero=0 → 0x100.
4. jal 0x0000400 at pc=0x2000_0010 → pc=0x2000_1000, link_addr=0x2000_0014. jr with Read_data_1=0x46 → pc=0x44 and addr_err=1, still set after later instructions.
5. stall=1 for 5 EXEC cycles → exec_en=0, pc and Instruction frozen. Release stall → single commit pulse.
6. reset=0 asserted mid-FETCH while ready pending, ready pulsed during BOOT → pc=RESET_PC, no Instruction capture in BOOT, fresh fetch from address 0. Separately, wrap case: pc=0xFFFF_FFFC with a sequential instruction → pc=0.
